rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/rr_mux.sv | 140 ++++++++++++++
 tb/tb_rr_mux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// +----------------------------------------------------------------------------+
// | mux_pkg : shared mode encodings and counter width for rr_mux               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_FORCED = 1'b1;
  localparam int   CNT_W       = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin search from ptr with wrap-around,   |
// |              one-hot grant plus encoded index.  Rev 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      // ptr + i is one bit wider so the wrap back below N_CH is exact
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_CH)) begin
        sum = sum - (IW+1)'(N_CH);
      end
      cand = sum[IW-1:0];
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux.sv
// +----------------------------------------------------------------------------+
// | rr_mux : N_CH-to-1 registered mux, round-robin or forced channel select.   |
// | Optional RR_MUX_CNT_EN adds a 16-bit output-transfer counter.  Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_mux
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*W-1:0]         in_data,
  input  logic [N_CH-1:0]           in_valid,
  output logic [N_CH-1:0]           in_ready,
  input  logic                      mode,
  input  logic [$clog2(N_CH)-1:0]   sel,
  output logic [W-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef RR_MUX_CNT_EN
  output logic [CNT_W-1:0]          xfer_cnt,
`endif
  output logic [$clog2(N_CH)-1:0]   out_ch
);

  localparam int IW = $clog2(N_CH);

  logic [W-1:0]    ch_data [N_CH];
  logic [N_CH-1:0] rr_grant;
  logic [IW-1:0]   rr_idx;
  logic            rr_any;
  logic [N_CH-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            sel_ok;
  logic            slot_free;
  logic            accept;
  logic            out_xfer;

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [IW-1:0]   out_ch_q,    out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   ptr_q,       ptr_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*W +: W];
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_arb (
    .valid (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign sel_ok    = ({1'b0, sel} < (IW+1)'(N_CH));
  assign slot_free = !out_valid_q || out_ready;
  assign out_xfer  = out_valid_q && out_ready;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else if (sel_ok && in_valid[sel]) begin
      grant[sel] = 1'b1;
      grant_idx  = sel;
    end
  end

  // Ready is suppressed during reset so nothing is acknowledged that cycle
  assign in_ready = (slot_free && !rst) ? grant : '0;
  assign accept   = |in_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (grant_idx == IW'(N_CH-1)) ? '0 : grant_idx + IW'(1);
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef RR_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_mux.sv
// +----------------------------------------------------------------------------+
// | tb_rr_mux : directed self-checking bench for rr_mux (N_CH=4, W=8).         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [1:0]        sel;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
`ifdef RR_MUX_CNT_EN
  logic [15:0]       xfer_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_mux #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RR_MUX_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_ch    (out_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    tick();
    settle();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_ch",    32'(out_ch),    32'h0);

    // All channels valid: strict rotation, one word per cycle
    rst = 1'b0;
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      chk("rr_out_ch",    32'(out_ch),    32'(i % 4));
      chk("rr_out_data",  32'(out_data),  32'(8'h10 + (i % 4)));
      chk("rr_out_valid", 32'(out_valid), 32'h1);
    end

    // Single requester ch2, then ch0/ch3 contention resolved from ptr=3
    in_valid = 4'b0100;
    in_data  = {8'h33, 8'hA5, 8'h11, 8'h30};
    settle();
    chk("ch2_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk("ch2_out_data", 32'(out_data), 32'hA5);
    chk("ch2_out_ch",   32'(out_ch),   32'h2);
    chk("ch2_ptr",      32'(dut.ptr_q), 32'h3);
    in_valid = 4'b1001;
    settle();
    chk("cont_in_ready", 32'(in_ready), 32'h8);
    tick();
    chk("cont_out_ch",   32'(out_ch),   32'h3);
    chk("cont_out_data", 32'(out_data), 32'h33);

    // Backpressure for three cycles, then release without a bubble
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_in_ready",  32'(in_ready),  32'h0);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_out_data",  32'(out_data),  32'h33);
      chk("bp_out_ch",    32'(out_ch),    32'h3);
    end
    out_ready = 1'b1;
    settle();
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("rel_out_valid", 32'(out_valid), 32'h1);
    chk("rel_out_ch",    32'(out_ch),    32'h0);
    chk("rel_out_data",  32'(out_data),  32'h30);

    // Forced select of ch1 with ch0 also valid; ptr must not move from 1
    mode     = 1'b1;
    sel      = 2'd1;
    in_valid = 4'b0011;
    in_data  = {8'h33, 8'hA5, 8'h41, 8'h30};
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("frc_in_ready", 32'(in_ready), 32'h2);
      tick();
      chk("frc_out_ch",   32'(out_ch),   32'h1);
      chk("frc_out_data", 32'(out_data), 32'h41);
    end
    chk("frc_ptr", 32'(dut.ptr_q), 32'h1);
    in_valid = 4'b0001;
    settle();
    chk("frc_nogrant", 32'(in_ready), 32'h0);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_out_ch",    32'(out_ch),    32'h1);
    chk("drain_out_data",  32'(out_data),  32'h41);
    sel = 2'd0;
    settle();
    chk("sel_chg_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("sel_chg_out_ch", 32'(out_ch),    32'h0);
    chk("sel_chg_ptr",    32'(dut.ptr_q), 32'h1);

    // Mid-stream reset with a word held
    mode     = 1'b0;
    in_valid = 4'b1111;
    rst      = 1'b1;
    settle();
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_out_valid", 32'(out_valid),  32'h0);
    chk("mid_rst_out_ch",    32'(out_ch),     32'h0);
    chk("mid_rst_ptr",       32'(dut.ptr_q),  32'h0);
    rst      = 1'b0;
    in_valid = 4'b0110;
    settle();
    chk("post_rst_in_ready", 32'(in_ready), 32'h2);
    tick();
    chk("post_rst_out_ch", 32'(out_ch), 32'h1);

`ifdef RR_MUX_CNT_EN
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b1111;
    chk("cnt_reset", 32'(xfer_cnt), 32'h0);
    repeat (70000) tick();
    in_valid = 4'b0000;
    tick();
    chk("cnt_wrap", 32'(xfer_cnt), 32'd4464);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
